// File: rtl/mc_control.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory wait timeout.
// Latency: strobes are combinational from state; 3 cycles (BEQ), 4 (R-type, SW), 5 (LW) with zero memory wait.
// Backpressure: stalls in FETCH/MEM until mem_ready; abandons the access after TMO not-ready cycles.
//
// Ports:
//   clk, rst_n (sync, active-low), Clear (sync flush)
//   in        opcode sampled when the IR loads (0 R-type, 1 LW, 2 SW, 3 BEQ, others illegal)
//   mem_ready memory access completes this cycle
//   zero      ALU zero flag, consumed by BEQ in EXEC
//   PCWrite..ALUOp  datapath strobes
//   state     current state, done/illegal/timeout one-cycle pulses, count retired instructions
module mc_control #(
    parameter int OPW = 2,
    parameter int CW  = 16,
    parameter int TMO = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           Clear,
    input  logic [OPW-1:0] in,
    input  logic           mem_ready,
    input  logic           zero,
    output logic           PCWrite,
    output logic           IRWrite,
    output logic           RegDst,
    output logic           RegWrite,
    output logic           ALUSrc,
    output logic           Branch,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           MemtoReg,
    output logic           ALUOp,
    output logic [2:0]     state,
    output logic           done,
    output logic           illegal,
    output logic           timeout,
    output logic [CW-1:0]  count
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    localparam logic [1:0] OP_R   = 2'd0;
    localparam logic [1:0] OP_LW  = 2'd1;
    localparam logic [1:0] OP_SW  = 2'd2;
    localparam logic [1:0] OP_BEQ = 2'd3;

    localparam int WW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    logic [2:0]     stateQ;
    logic [2:0]     nextState;
    logic [OPW-1:0] opQ;
    logic [OPW-1:0] opHi;
    logic [1:0]     opLo;
    logic           legal;
    logic [WW-1:0]  waitCnt;
    logic           waitHit;
    logic [CW-1:0]  countQ;

    // Opcodes above 3 are illegal; only the upper bits need inspecting.
    assign opHi  = opQ >> 2;
    assign legal = (opHi == '0);
    assign opLo  = opQ[1:0];

    // The cycle in which the TMO-th consecutive not-ready cycle is observed.
    // mem_ready in that same cycle still wins.
    assign waitHit = (waitCnt == WW'(TMO - 1));

    assign state = stateQ;
    assign count = countQ;

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        RegWrite  = 1'b0;
        ALUSrc    = 1'b0;
        Branch    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        ALUOp     = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        timeout   = 1'b0;
        nextState = stateQ;

        if (Clear) begin
            nextState = FETCH;
        end else if (rst_n) begin
            case (stateQ)
                FETCH: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        nextState = DECODE;
                    end else if (waitHit) begin
                        timeout   = 1'b1;
                        nextState = FETCH;
                    end
                end
                DECODE: begin
                    if (legal) begin
                        nextState = EXEC;
                    end else begin
                        illegal   = 1'b1;
                        nextState = FETCH;
                    end
                end
                EXEC: begin
                    case (opLo)
                        OP_R: begin
                            ALUOp     = 1'b1;
                            nextState = WB;
                        end
                        OP_LW, OP_SW: begin
                            ALUSrc    = 1'b1;
                            ALUOp     = 1'b1;
                            nextState = MEM;
                        end
                        default: begin
                            Branch    = 1'b1;
                            PCWrite   = zero;
                            done      = 1'b1;
                            nextState = FETCH;
                        end
                    endcase
                end
                MEM: begin
                    if (opLo == OP_LW) begin
                        MemRead = 1'b1;
                    end else begin
                        MemWrite = 1'b1;
                    end
                    if (mem_ready) begin
                        if (opLo == OP_LW) begin
                            nextState = WB;
                        end else begin
                            done      = 1'b1;
                            nextState = FETCH;
                        end
                    end else if (waitHit) begin
                        timeout   = 1'b1;
                        nextState = FETCH;
                    end
                end
                WB: begin
                    RegWrite = 1'b1;
                    if (opLo == OP_R) begin
                        RegDst = 1'b1;
                    end else begin
                        MemtoReg = 1'b1;
                    end
                    done      = 1'b1;
                    nextState = FETCH;
                end
                default: begin
                    nextState = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ  <= FETCH;
            opQ     <= '0;
            countQ  <= '0;
            waitCnt <= '0;
        end else begin
            stateQ <= nextState;
            if (Clear) begin
                // Flush: opcode and retire count are kept.
                waitCnt <= '0;
            end else begin
                if (stateQ == FETCH && mem_ready) begin
                    opQ <= in;
                end
                if (done) begin
                    countQ <= countQ + 1'b1;
                end
                // Any state change or timeout re-entry counts as a fresh entry.
                if (nextState != stateQ || timeout) begin
                    waitCnt <= '0;
                end else if ((stateQ == FETCH || stateQ == MEM) && !mem_ready) begin
                    waitCnt <= waitCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    localparam int OPW = 3;
    localparam int CW  = 2;
    localparam int TMO = 15;

    // Strobe vector: {PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp}
    localparam logic [9:0] PCW  = 10'h200;
    localparam logic [9:0] IRW  = 10'h100;
    localparam logic [9:0] RDST = 10'h080;
    localparam logic [9:0] RW   = 10'h040;
    localparam logic [9:0] ASRC = 10'h020;
    localparam logic [9:0] BR   = 10'h010;
    localparam logic [9:0] MR   = 10'h008;
    localparam logic [9:0] MW   = 10'h004;
    localparam logic [9:0] M2R  = 10'h002;
    localparam logic [9:0] AOP  = 10'h001;
    // Pulse vector: {done, illegal, timeout}
    localparam logic [2:0] DN = 3'b100;
    localparam logic [2:0] IL = 3'b010;
    localparam logic [2:0] TO = 3'b001;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           Clear;
    logic [OPW-1:0] in;
    logic           mem_ready;
    logic           zero;
    logic           PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, Branch;
    logic           MemRead, MemWrite, MemtoReg, ALUOp;
    logic [2:0]     state;
    logic           done, illegal, timeout;
    logic [CW-1:0]  count;

    int             nCmp = 0;
    int             nErr = 0;
    logic [1:0]     expCnt = 2'd0;
    logic [17:0]    sbQueue[$];

    mc_control #(.OPW(OPW), .CW(CW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .Clear(Clear), .in(in),
        .mem_ready(mem_ready), .zero(zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .ALUOp(ALUOp), .state(state),
        .done(done), .illegal(illegal), .timeout(timeout), .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare on the falling edge.
    task automatic step(input string tag, input logic rstN, input logic clr,
                        input logic [OPW-1:0] inV, input logic mr, input logic z,
                        input logic [2:0] st, input logic [9:0] sb, input logic [2:0] pl);
        logic [17:0] e;
        logic [17:0] obs;
        @(posedge clk);
        #1;
        rst_n     = rstN;
        Clear     = clr;
        in        = inV;
        mem_ready = mr;
        zero      = z;
        sbQueue.push_back({st, sb, pl, expCnt});
        @(negedge clk);
        e   = sbQueue.pop_front();
        obs = {state, PCWrite, IRWrite, RegDst, RegWrite, ALUSrc, Branch, MemRead,
               MemWrite, MemtoReg, ALUOp, done, illegal, timeout, count};
        checkVal(tag, {14'd0, obs}, {14'd0, e});
        if (!rstN) begin
            expCnt = 2'd0;
        end else if (pl[2]) begin
            expCnt = expCnt + 2'd1;
        end
    endtask

    task automatic fetchDec(input string tag, input logic [OPW-1:0] op);
        step({tag, ".fetch"}, 1'b1, 1'b0, op, 1'b1, 1'b0, 3'd0, MR | IRW | PCW, 3'b000);
        step({tag, ".dec"},   1'b1, 1'b0, op, 1'b1, 1'b0, 3'd1, 10'h000, 3'b000);
    endtask

    task automatic rtype(input string tag);
        fetchDec(tag, 3'd0);
        step({tag, ".exec"}, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, AOP, 3'b000);
        step({tag, ".wb"},   1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd4, RW | RDST, DN);
    endtask

    initial begin
        rst_n     = 1'b0;
        Clear     = 1'b0;
        in        = '0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held with active-looking inputs: every output except state/count is 0.
        step("rst", 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 3'd0, 10'h000, 3'b000);

        // R-type with memory always ready.
        rtype("rt");

        // LW: memory withheld three cycles in MEM.
        fetchDec("lw", 3'd1);
        step("lw.exec", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 3'd2, ASRC | AOP, 3'b000);
        for (int i = 0; i < 3; i++)
            step("lw.memwait", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 3'd3, MR, 3'b000);
        step("lw.memrdy", 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 3'd3, MR, 3'b000);
        step("lw.wb",     1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 3'd4, RW | M2R, DN);

        // BEQ taken then not taken.
        fetchDec("beq1", 3'd3);
        step("beq1.exec", 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 3'd2, BR | PCW, DN);
        fetchDec("beq0", 3'd3);
        step("beq0.exec", 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd2, BR, DN);

        // SW timing out after TMO not-ready cycles in MEM.
        fetchDec("swto", 3'd2);
        step("swto.exec", 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd2, ASRC | AOP, 3'b000);
        for (int i = 0; i < TMO - 1; i++)
            step("swto.memwait", 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd3, MW, 3'b000);
        step("swto.timeout", 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd3, MW, TO);

        // SW whose ready arrives in the last permitted cycle: success, no timeout.
        fetchDec("swok", 3'd2);
        step("swok.exec", 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd2, ASRC | AOP, 3'b000);
        for (int i = 0; i < TMO - 1; i++)
            step("swok.memwait", 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd3, MW, 3'b000);
        step("swok.edge", 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 3'd3, MW, DN);

        // Fetch timeout: stays in FETCH.
        for (int i = 0; i < TMO - 1; i++)
            step("fto.wait", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, MR, 3'b000);
        step("fto.timeout", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, MR, TO);

        // Illegal opcode.
        step("ill.fetch", 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, MR | IRW | PCW, 3'b000);
        step("ill.dec",   1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 3'd1, 10'h000, IL);

        // Clear during LW MEM with memory ready: no retire, back to FETCH.
        fetchDec("clr", 3'd1);
        step("clr.exec", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 3'd2, ASRC | AOP, 3'b000);
        step("clr.mem",  1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 3'd3, 10'h000, 3'b000);
        step("clr.after", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0, MR, 3'b000);

        // Four R-types: count wraps through zero.
        for (int i = 0; i < 4; i++)
            rtype("wrap");

        // Reset in WB: no done, count cleared.
        fetchDec("rstmid", 3'd0);
        step("rstmid.exec", 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, AOP, 3'b000);
        step("rstmid.wb",   1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd4, 10'h000, 3'b000);
        step("rstmid.after", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, MR, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
